// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

   localparam int BOOTH_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } booth_state_e;

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: conditional add/subtract of Mx into ACC, then arithmetic shift of P.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_WIDTH_DEF
) (
   input  logic [2*WIDTH+1:0] p_i,
   input  logic [WIDTH:0]     mx_i,
   output logic [2*WIDTH+1:0] p_o
);

   logic [WIDTH:0] acc;
   logic [WIDTH:0] acc_sum;

   always_comb begin
      acc = p_i[2*WIDTH+1:WIDTH+1];
      unique case (p_i[1:0])
         2'b01:   acc_sum = acc + mx_i;
         2'b10:   acc_sum = acc - mx_i;
         default: acc_sum = acc;
      endcase
      // q-1 (old P[0]) falls off the bottom; ACC sign bit is replicated at the top.
      p_o = {acc_sum[WIDTH], acc_sum, p_i[WIDTH:1]};
   end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller; one iteration per clock, WIDTH iterations.
// Optional abort input enabled by defining BOOTH_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start=1
// RUN   | one add/sub + shift step per cycle until cnt reaches WIDTH
// DONE  | latch product, pulse done, return to IDLE
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
`ifdef BOOTH_ABORT_EN
   input  logic                 abort,
`endif
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   booth_state_e state_q, state_d;
   logic [2*WIDTH+1:0] p_q, p_d, p_step;
   logic [WIDTH:0]     mx_q, mx_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               done_q, done_d;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .p_i  (p_q),
      .mx_i (mx_q),
      .p_o  (p_step)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         p_q       <= '0;
         mx_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         mx_q      <= mx_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      mx_d      = mx_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               p_d     = {{(WIDTH+1){1'b0}}, multiplier, 1'b0};
               mx_d    = {multiplicand[WIDTH-1], multiplicand};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef BOOTH_ABORT_EN
            if (abort) begin
               state_d = IDLE;
            end else begin
               p_d   = p_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_LAST) state_d = DONE;
            end
`else
            p_d   = p_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_LAST) state_d = DONE;
`endif
         end
         DONE: begin
            product_d = p_q[2*WIDTH:1];
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // busy covers the done cycle too, so it drops together with the done pulse.
   assign busy    = (state_q != IDLE) | done_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequential radix-2 Booth multiplier controller for the signed multiply path. It accepts two signed operands on a start pulse and owns the partial-product register. It sequences one add/subtract plus arithmetic-shift step per clock for WIDTH iterations, then presents the signed 2·WIDTH-bit product with a one-cycle done pulse. It sits between the odometry/control arithmetic that requests products and the Booth add/shift datapath.

## Interface
- WIDTH, 32, operand width in bits; product is 2·WIDTH bits.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  signed operand M; captured on the accepted start.
- multiplier  input  WIDTH  signed operand Q; captured on the accepted start.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2·WIDTH  signed result; held until the next accepted start.
- abort  input  1  present only with BOOTH_ABORT_EN.

## Operation
- Registers:
  - P, 2·WIDTH+2 bits: {ACC (WIDTH+1), Q (WIDTH), q₋₁ (1)}.
  - Mx: M sign-extended to WIDTH+1 bits.
  - cnt: iteration counter, $clog2(WIDTH+1) bits.
- The accumulator is WIDTH+1 bits so that M = −2^(WIDTH−1) is exact.
  - ACC ± Mx is modulo 2^(WIDTH+1); the carry is discarded.
- States:
  - IDLE: start=1 loads ACC=0, Q=multiplier, q₋₁=0, Mx=sext(multiplicand), cnt=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle, examine {P[1],P[0]}:
    - 01: ACC ← ACC + Mx.
    - 10: ACC ← ACC − Mx.
    - 00 or 11: no change.
    - Then arithmetic-shift the whole P right by 1, replicating the ACC MSB, and increment cnt.
    - The step that brings cnt to WIDTH transitions to DONE.
  - DONE: product ← P[2·WIDTH:1], done=1, then go to IDLE unconditionally.
- start in RUN or DONE is ignored and is not queued.
- Operands are not re-sampled after load; input changes during RUN have no effect.
- rst has priority over every event.
  - It returns state to IDLE and clears P, Mx, cnt, product, busy and done, including in the middle of RUN.

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE, cnt=0.
- Start accepted at edge E0. RUN occupies the cycles after edges E1…E(WIDTH).
- After edge E(WIDTH+1), done=1 and product is valid: latency WIDTH+1 cycles, i.e. 33 for the default.
- busy rises the cycle after E0 and falls together with done (on the edge after E(WIDTH+1)).
- Minimum start-to-start spacing is WIDTH+2 cycles; start may be held high continuously.
- product is registered and changes only on the DONE transition or on reset.

## Configuration
- BOOTH_ABORT_EN defined:
  - Adds the abort port.
  - abort=1 in RUN returns to IDLE on the next edge, with no done pulse and product unchanged.
  - abort in IDLE or DONE is ignored.
  - rst still has priority.
- BOOTH_ABORT_EN undefined:
  - No abort port; every accepted start completes.

## Structure
- Shared package booth_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the default WIDTH constant.
- Sub-module booth_step (combinational):
  - Inputs: P and Mx. Output: next P.
  - Performs the add/subtract on the upper WIDTH+1 bits followed by the arithmetic shift.
  - The controller instantiates it once and registers its output.

## Test plan
- Reset: assert rst for 2 cycles mid-RUN → busy=0, done=0, product=0. A fresh start of 3×5 then completes normally with product=15.
- 3 × 5 → product=0x0000_0000_0000_000F; done exactly 33 cycles after the start edge, for exactly one cycle.
- −7 × 6 → product=0xFFFF_FFFF_FFFF_FFD6. Changing the operand inputs during RUN does not alter the result.
- 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000; 0x8000_0000 × 0x7FFF_FFFF → 0xC000_0000_8000_0000.
- Hold start high across two operations → the second is accepted only in IDLE, with done pulses 34 cycles apart. start pulses in RUN and DONE produce no extra done.
- BOOTH_ABORT_EN: abort at iteration 10 of 3×5 → busy=0 next cycle, no done pulse, product keeps its previous value. A following start still yields the correct product.
